// File: rtl/sy_ppl_compress_enc.sv
// sy_ppl_compress_enc: RV64 to RVC compressor feeding a halfword-to-word packer with stream-end padding.
// Optional SY_COMPRESS_FP_EN also compresses fld/fsd into c.fld/c.fsd/c.fldsp/c.fsdsp.
module sy_ppl_compress_enc #(
    parameter bit CMP_EN = 1'b1,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_instr_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_word_o,
    output logic             out_last_o,
    output logic [CNT_W-1:0] cmp_cnt_o,
    output logic [CNT_W-1:0] word_cnt_o
);
    typedef enum logic [1:0] {S_EMPTY, S_HALF, S_FLUSH} state_t;

    // Returns {hit, halfword}; hit only when an exact RVC equivalent exists.
    function automatic logic [16:0] compress(input logic [31:0] i);
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3, op;
        logic [6:0] f7;
        logic signed [11:0] ii, is;
        logic rdp, rs1p, rs2p, fp, w, d;
        rd = i[11:7];
        rs1 = i[19:15];
        rs2 = i[24:20];
        f3 = i[14:12];
        f7 = i[31:25];
        ii = i[31:20];
        is = {i[31:25], i[11:7]};
        rdp = rd[4:3] == 2'b01;
        rs1p = rs1[4:3] == 2'b01;
        rs2p = rs2[4:3] == 2'b01;
`ifdef SY_COMPRESS_FP_EN
        fp = 1'b1;
`else
        fp = 1'b0;
`endif
        w = f3 == 3'b010 && !i[2];
        d = f3 == 3'b011 && (!i[2] || fp);
        op = w ? 3'b010 : i[2] ? 3'b001 : 3'b011;
        compress = '0;
        case (i[6:0])
            7'b0010011: begin
                if (f3 == 3'b000) begin
                    if (rd == 0 && rs1 == 0 && ii == 0)
                        compress = {1'b1, 16'h0001};
                    else if (rd != 0 && rs1 == rd && ii != 0 && ii >= -32 && ii <= 31)
                        compress = {1'b1, 3'b000, ii[5], rd, ii[4:0], 2'b01};
                    else if (rd != 0 && rs1 == 0 && ii >= -32 && ii <= 31)
                        compress = {1'b1, 3'b010, ii[5], rd, ii[4:0], 2'b01};
                    else if (rd == 2 && rs1 == 2 && ii != 0 && ii[3:0] == 0 && ii >= -512 && ii <= 496)
                        compress = {1'b1, 3'b011, ii[9], 5'd2, ii[4], ii[6], ii[8:7], ii[5], 2'b01};
                    else if (rdp && rs1 == 2 && ii[1:0] == 0 && ii >= 4 && ii <= 1020)
                        compress = {1'b1, 3'b000, ii[5:4], ii[9:6], ii[2], ii[3], rd[2:0], 2'b00};
                end else if (f3 == 3'b001) begin
                    if (i[31:26] == 0 && rd != 0 && rs1 == rd && i[25:20] != 0)
                        compress = {1'b1, 3'b000, i[25], rd, i[24:20], 2'b10};
                end else if (f3 == 3'b101) begin
                    if ((i[31:26] == 6'b000000 || i[31:26] == 6'b010000) && rdp && rs1 == rd && i[25:20] != 0)
                        compress = {1'b1, 3'b100, i[25], 1'b0, i[30], rd[2:0], i[24:20], 2'b01};
                end else if (f3 == 3'b111) begin
                    if (rdp && rs1 == rd && ii >= -32 && ii <= 31)
                        compress = {1'b1, 3'b100, ii[5], 2'b10, rd[2:0], ii[4:0], 2'b01};
                end
            end
            7'b0011011: begin
                if (f3 == 3'b000 && rd != 0 && rs1 == rd && ii >= -32 && ii <= 31)
                    compress = {1'b1, 3'b001, ii[5], rd, ii[4:0], 2'b01};
            end
            7'b0110111: begin
                if (rd != 0 && rd != 2 && i[31:12] != 0 && i[31:17] == {15{i[17]}})
                    compress = {1'b1, 3'b011, i[17], rd, i[16:12], 2'b01};
            end
            7'b0110011: begin
                if (f7 == 0 && f3 == 0 && rd != 0 && rs2 != 0 && rs1 == 0)
                    compress = {1'b1, 4'b1000, rd, rs2, 2'b10};
                else if (f7 == 0 && f3 == 0 && rd != 0 && rs2 != 0 && rs1 == rd)
                    compress = {1'b1, 4'b1001, rd, rs2, 2'b10};
                else if (rdp && rs2p && rs1 == rd &&
                         ((f7 == 7'b0100000 && f3 == 3'b000) ||
                          (f7 == 0 && (f3 == 3'b100 || f3 == 3'b110 || f3 == 3'b111))))
                    compress = {1'b1, 6'b100011, rd[2:0], f3[1], f3[2] & ~f3[1] | f3[0], rs2[2:0], 2'b01};
            end
            7'b0111011: begin
                if (rdp && rs2p && rs1 == rd && f3 == 3'b000 && (f7 == 7'b0100000 || f7 == 0))
                    compress = {1'b1, 6'b100111, rd[2:0], 1'b0, ~f7[5], rs2[2:0], 2'b01};
            end
            7'b1100111: begin
                if (f3 == 0 && ii == 0 && rs1 != 0 && (rd == 0 || rd == 1))
                    compress = {1'b1, 3'b100, rd[0], rs1, 5'd0, 2'b10};
            end
            7'b1110011: begin
                if (i == 32'h0010_0073)
                    compress = {1'b1, 16'h9002};
            end
            7'b0000011, 7'b0000111: begin
                if (rs1 == 2 && rd != 0 && w && ii[1:0] == 0 && ii >= 0 && ii <= 252)
                    compress = {1'b1, 3'b010, ii[5], rd, ii[4:2], ii[7:6], 2'b10};
                else if (rs1 == 2 && rd != 0 && d && ii[2:0] == 0 && ii >= 0 && ii <= 504)
                    compress = {1'b1, op, ii[5], rd, ii[4:3], ii[8:6], 2'b10};
                else if (rdp && rs1p && w && ii[1:0] == 0 && ii >= 0 && ii <= 124)
                    compress = {1'b1, 3'b010, ii[5:3], rs1[2:0], ii[2], ii[6], rd[2:0], 2'b00};
                else if (rdp && rs1p && d && ii[2:0] == 0 && ii >= 0 && ii <= 248)
                    compress = {1'b1, op, ii[5:3], rs1[2:0], ii[7:6], rd[2:0], 2'b00};
            end
            7'b0100011, 7'b0100111: begin
                if (rs1 == 2 && w && is[1:0] == 0 && is >= 0 && is <= 252)
                    compress = {1'b1, 3'b110, is[5:2], is[7:6], rs2, 2'b10};
                else if (rs1 == 2 && d && is[2:0] == 0 && is >= 0 && is <= 504)
                    compress = {1'b1, op | 3'b100, is[5:3], is[8:6], rs2, 2'b10};
                else if (rs1p && rs2p && w && is[1:0] == 0 && is >= 0 && is <= 124)
                    compress = {1'b1, 3'b110, is[5:3], rs1[2:0], is[2], is[6], rs2[2:0], 2'b00};
                else if (rs1p && rs2p && d && is[2:0] == 0 && is >= 0 && is <= 248)
                    compress = {1'b1, op | 3'b100, is[5:3], rs1[2:0], is[7:6], rs2[2:0], 2'b00};
            end
            default: compress = '0;
        endcase
    endfunction

    state_t state;
    logic [15:0] res, lo, hi;
    logic [16:0] c;
    logic one, acc, out_free, split;

    assign c = CMP_EN ? compress(in_instr_i) : 17'd0;
    // Pre-compressed halfwords never match a 32-bit opcode, so c[16] implies a full-width source.
    assign one = in_instr_i[1:0] != 2'b11 || c[16];
    assign lo = c[16] ? c[15:0] : in_instr_i[15:0];
    assign hi = in_instr_i[31:16];
    assign out_free = !out_valid_o || out_ready_i;
    assign in_ready_o = state != S_FLUSH && out_free;
    assign acc = in_valid_i && in_ready_o;
    assign split = state == S_HALF && !one;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_EMPTY;
            res <= '0;
            out_valid_o <= 1'b0;
            out_word_o <= '0;
            out_last_o <= 1'b0;
            cmp_cnt_o <= '0;
            word_cnt_o <= '0;
        end else begin
            if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
                word_cnt_o <= word_cnt_o + CNT_W'(1);
            end
            if (state == S_FLUSH && out_free) begin
                out_valid_o <= 1'b1;
                out_word_o <= {16'h0001, res};
                out_last_o <= 1'b1;
                state <= S_EMPTY;
            end else if (acc) begin
                cmp_cnt_o <= cmp_cnt_o + CNT_W'(one);
                if (state == S_EMPTY && one && !in_last_i) begin
                    res <= lo;
                    state <= S_HALF;
                end else begin
                    out_valid_o <= 1'b1;
                    out_word_o <= state == S_EMPTY ? (one ? {16'h0001, lo} : {hi, lo}) : {lo, res};
                    out_last_o <= in_last_i && !split;
                    res <= hi;
                    state <= split ? (in_last_i ? S_FLUSH : S_HALF) : S_EMPTY;
                end
            end
        end
    end
endmodule

// File: tb/tb_sy_ppl_compress_enc.sv
// tb_sy_ppl_compress_enc: directed bench for the compressor/packer, with a CMP_EN=0 instance alongside.
module tb_sy_ppl_compress_enc;
    logic clk, rst;
    logic in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [31:0] in_instr, out_word, cmp_cnt, word_cnt;
    logic r_valid, r_ready, r_last, r_ovalid, r_olast;
    logic [31:0] r_instr, r_word, r_cmp, r_wcnt;
    int checks = 0;
    int failures = 0;

    sy_ppl_compress_enc #(.CMP_EN(1'b1), .CNT_W(32)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr), .in_last_i(in_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_word_o(out_word), .out_last_o(out_last),
        .cmp_cnt_o(cmp_cnt), .word_cnt_o(word_cnt)
    );

    sy_ppl_compress_enc #(.CMP_EN(1'b0), .CNT_W(32)) u_raw (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(r_valid), .in_ready_o(r_ready), .in_instr_i(r_instr), .in_last_i(r_last),
        .out_valid_o(r_ovalid), .out_ready_i(1'b1), .out_word_o(r_word), .out_last_o(r_olast),
        .cmp_cnt_o(r_cmp), .word_cnt_o(r_wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic last);
        in_valid = v;
        in_instr = instr;
        in_last = last;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        out_ready = 1'b1;
        r_valid = 1'b0;
        r_instr = 32'h0;
        r_last = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_word", out_word, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_cmp", cmp_cnt, 32'd0);
        chk("rst_wcnt", word_cnt, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        drive(1'b1, 32'h0014_0413, 1'b0);
        cyc();
        chk("t1_no_word_yet", {31'd0, out_valid}, 32'd0);
        cyc();
        drive(1'b0, 32'h0, 1'b0);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_word", out_word, 32'h0405_0405);
        chk("t1_last", {31'd0, out_last}, 32'd0);
        chk("t1_cmp", cmp_cnt, 32'd2);
        cyc();
        chk("t1_drained", {31'd0, out_valid}, 32'd0);
        chk("t1_wcnt", word_cnt, 32'd1);

        drive(1'b1, 32'h00B0_0533, 1'b0);
        cyc();
        drive(1'b1, 32'h0044_2483, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 1'b0);
        chk("t2_word", out_word, 32'h4044_852E);
        chk("t2_last", {31'd0, out_last}, 32'd1);
        chk("t2_cmp", cmp_cnt, 32'd4);
        cyc();
        chk("t2_wcnt", word_cnt, 32'd2);

        drive(1'b1, 32'h0000_0405, 1'b0);
        cyc();
        drive(1'b1, 32'h0080_00EF, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 1'b0);
        chk("t3_word1", out_word, 32'h00EF_0405);
        chk("t3_last1", {31'd0, out_last}, 32'd0);
        chk("t3_flush_blocks", {31'd0, in_ready}, 32'd0);
        chk("t3_cmp", cmp_cnt, 32'd5);
        cyc();
        chk("t3_valid2", {31'd0, out_valid}, 32'd1);
        chk("t3_word2", out_word, 32'h0001_0080);
        chk("t3_last2", {31'd0, out_last}, 32'd1);
        chk("t3_wcnt1", word_cnt, 32'd3);
        cyc();
        chk("t3_wcnt2", word_cnt, 32'd4);
        chk("t3_ready_again", {31'd0, in_ready}, 32'd1);

        drive(1'b1, 32'h0014_0413, 1'b1);
        cyc();
        drive(1'b1, 32'h0014_0413, 1'b0);
        out_ready = 1'b0;
        chk("t4_word", out_word, 32'h0001_0405);
        chk("t4_last", {31'd0, out_last}, 32'd1);
        chk("t4_cmp", cmp_cnt, 32'd6);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t5_hold_word", out_word, 32'h0001_0405);
            chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t5_hold_ready", {31'd0, in_ready}, 32'd0);
            chk("t5_hold_wcnt", word_cnt, 32'd4);
            chk("t5_hold_cmp", cmp_cnt, 32'd6);
        end
        drive(1'b0, 32'h0, 1'b0);
        out_ready = 1'b1;
        cyc();
        chk("t5_release_wcnt", word_cnt, 32'd5);
        chk("t5_release_valid", {31'd0, out_valid}, 32'd0);

        drive(1'b1, 32'h0000_0013, 1'b0);
        cyc();
        drive(1'b1, 32'h0010_0073, 1'b0);
        cyc();
        drive(1'b1, 32'h0081_3423, 1'b0);
        chk("t6_nop_ebreak", out_word, 32'h9002_0001);
        cyc();
        drive(1'b1, 32'h0081_3403, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0);
        chk("t6_sdsp_ldsp", out_word, 32'h6422_E422);
        chk("t6_cmp", cmp_cnt, 32'd10);
        cyc();

        drive(1'b1, 32'h0000_0405, 1'b0);
        cyc();
        drive(1'b1, 32'h0080_00EF, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 1'b0);
        out_ready = 1'b0;
        chk("t7_in_flush", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("t7_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t7_rst_cmp", cmp_cnt, 32'd0);
        chk("t7_rst_wcnt", word_cnt, 32'd0);
        chk("t7_rst_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'h0014_0413, 1'b1);
        r_valid = 1'b1;
        r_instr = 32'h0014_0413;
        r_last = 1'b1;
        cyc();
        drive(1'b0, 32'h0, 1'b0);
        r_valid = 1'b0;
        chk("t7_empty_word", out_word, 32'h0001_0405);
        chk("raw_valid", {31'd0, r_ovalid}, 32'd1);
        chk("raw_word", r_word, 32'h0014_0413);
        chk("raw_last", {31'd0, r_olast}, 32'd1);
        chk("raw_cmp", r_cmp, 32'd0);
        cyc();
        chk("raw_wcnt", r_wcnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
